// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - restoring iterative divider, one quotient bit per cycle, valid/ready on both sides
// Define DIV_SIGNED_EN to honour is_signed (RISC-V M semantics, including the MIN / -1 overflow case).
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_q_in, neg_r_in, ovf;
  logic             neg_q, neg_r;
  logic             accept, special;

`ifdef DIV_SIGNED_EN
  always_comb begin
    mag_a    = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b    = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
    neg_q_in = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    neg_r_in = is_signed & dividend[WIDTH-1];
    ovf      = is_signed & (dividend == MIN) & (&divisor);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_q_in;
      neg_r <= neg_r_in;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign mag_a    = dividend;
  assign mag_b    = divisor;
  assign neg_q_in = 1'b0;
  assign neg_r_in = 1'b0;
  assign ovf      = 1'b0;
  assign neg_q    = neg_q_in;
  assign neg_r    = neg_r_in;
`endif

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign special   = (divisor == '0) | ovf;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) | (state == FIX);

  // WIDTH+1-bit trial subtract: the shifted partial remainder can exceed WIDTH bits
  assign rem_sh = {rem_r, quo_r[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_r};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (out_ready) state_n = accept ? (special ? DONE : CALC) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r     <= '0;
      quo_r     <= '0;
      dvs_r     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end else if (ovf) begin
        quotient  <= MIN;
        remainder <= '0;
      end else begin
        rem_r <= '0;
        quo_r <= mag_a;
        dvs_r <= mag_b;
        cnt   <= CNT_W'(WIDTH);
      end
    end else if (state == CALC) begin
      rem_r <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_r <= {quo_r[WIDTH-2:0], ~diff[WIDTH]};
      cnt   <= cnt - CNT_W'(1);
    end else if (state == FIX) begin
      quotient  <= neg_q ? -quo_r : quo_r;
      remainder <= neg_r ? -rem_r : rem_r;
    end
  end
endmodule
